// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - merges W-stage and buffered LLU results onto the register-file write port
// Optional starvation forcing of the LLU head is compiled in with WB_ARB_STARVE_EN.
module wb_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          RegWriteW,
    input  logic [ADDR_WIDTH-1:0]         RdW,
    input  logic [DATA_WIDTH-1:0]         ResultW,
    input  logic                          llu_valid,
    input  logic [ADDR_WIDTH-1:0]         llu_rd,
    input  logic [DATA_WIDTH-1:0]         llu_data,
    output logic                          llu_ready,
    output logic                          WE3,
    output logic [ADDR_WIDTH-1:0]         A3,
    output logic [DATA_WIDTH-1:0]         WD3,
    output logic                          StallW,
    output logic [$clog2(FIFO_DEPTH):0]   llu_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  ready_en;
    logic                  head_valid;
    logic                  force_grant;
    logic                  grant_llu;
    logic                  push;
    logic                  pop;

    assign head_valid = (llu_count != '0);
    // ready_en holds the handshake off until the first edge after reset release
    assign llu_ready  = ready_en && (llu_count < DEPTH_C);
    assign push       = llu_valid && llu_ready && (llu_rd != '0);
    assign grant_llu  = head_valid && (!RegWriteW || force_grant);
    assign pop        = grant_llu;

`ifdef WB_ARB_STARVE_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);

    logic [WW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!head_valid || pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MAX_WAIT_C) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_grant = head_valid && (wait_cnt == MAX_WAIT_C);
    assign StallW      = rst_n && force_grant;
`else
    assign force_grant = 1'b0;
    assign StallW      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            llu_count <= '0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   llu_count <= llu_count + 1'b1;
                2'b01:   llu_count <= llu_count - 1'b1;
                default: llu_count <= llu_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= llu_rd;
            data_mem[wr_ptr] <= llu_data;
        end
    end

    always_comb begin
        WE3 = 1'b0;
        A3  = '0;
        WD3 = '0;
        if (rst_n) begin
            if (RegWriteW && !force_grant) begin
                WE3 = 1'b1;
                A3  = RdW;
                WD3 = ResultW;
            end else if (head_valid) begin
                WE3 = 1'b1;
                A3  = rd_mem[rd_ptr];
                WD3 = data_mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        llu_valid;
    logic [4:0]  llu_rd;
    logic [31:0] llu_data;
    logic        llu_ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        StallW;
    logic [1:0]  llu_count;

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [31:0] d;
        logic        s;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    wb_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .ResultW   (ResultW),
        .llu_valid (llu_valid),
        .llu_rd    (llu_rd),
        .llu_data  (llu_data),
        .llu_ready (llu_ready),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .StallW    (StallW),
        .llu_count (llu_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input logic s);
        exp_t e;
        e.cyc = cyc;
        e.a   = a;
        e.d   = d;
        e.s   = s;
        exp_q.push_back(e);
    endtask

    // Monitor: every write-port event must match the head of the expected queue in the same cycle
    always @(negedge clk) begin
        if (WE3) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we3", {27'd0, A3}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_a3", {27'd0, A3}, {27'd0, e.a});
                chk("wr_wd3", WD3, e.d);
                chk("wr_stall", {31'd0, StallW}, {31'd0, e.s});
            end
        end else begin
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                chk("missing_we3", {31'd0, WE3}, 32'd1);
                void'(exp_q.pop_front());
            end
            if (StallW) chk("stall_without_we3", {31'd0, StallW}, 32'd0);
        end
    end

    initial begin
        rst_n = 1'b0; RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h1234;
        llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
        #2;
        chk("rst_count", {30'd0, llu_count}, 32'd0);
        chk("rst_we3", {31'd0, WE3}, 32'd0);
        chk("rst_ready", {31'd0, llu_ready}, 32'd0);
        chk("rst_stall", {31'd0, StallW}, 32'd0);
        tick; tick;
        RegWriteW = 1'b0;
        rst_n = 1'b1;
        chk("ready_before_edge", {31'd0, llu_ready}, 32'd0);
        tick;
        chk("ready_after_edge", {31'd0, llu_ready}, 32'd1);

        // Pipeline write, FIFO empty: same cycle
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEAD_BEEF;
        expect_wr(5'd5, 32'hDEAD_BEEF, 1'b0);
        tick;
        RegWriteW = 1'b0;

        // Single LLU push, drained next cycle
        llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'h11;
        tick;
        llu_valid = 1'b0;
        chk("push1_count", {30'd0, llu_count}, 32'd1);
        expect_wr(5'd7, 32'h11, 1'b0);
        tick;
        chk("drain1_count", {30'd0, llu_count}, 32'd0);

        // Two pushes while pipeline owns the port, third refused
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'hA1;
        llu_valid = 1'b1; llu_rd = 5'd8; llu_data = 32'h88;
        expect_wr(5'd1, 32'hA1, 1'b0);
        tick;
        llu_rd = 5'd9; llu_data = 32'h99;
        chk("fill_ready1", {31'd0, llu_ready}, 32'd1);
        expect_wr(5'd1, 32'hA1, 1'b0);
        tick;
        llu_rd = 5'd10; llu_data = 32'hAA;
        chk("full_count", {30'd0, llu_count}, 32'd2);
        chk("full_ready", {31'd0, llu_ready}, 32'd0);
        expect_wr(5'd1, 32'hA1, 1'b0);
        tick;
        chk("third_refused", {30'd0, llu_count}, 32'd2);
        RegWriteW = 1'b0; llu_valid = 1'b0;
        expect_wr(5'd8, 32'h88, 1'b0);
        tick;
        expect_wr(5'd9, 32'h99, 1'b0);
        tick;
        chk("drain2_count", {30'd0, llu_count}, 32'd0);

        // rd==0 push: handshake completes but nothing is buffered
        llu_valid = 1'b1; llu_rd = 5'd0; llu_data = 32'h55;
        chk("rd0_ready", {31'd0, llu_ready}, 32'd1);
        tick;
        llu_valid = 1'b0;
        chk("rd0_count", {30'd0, llu_count}, 32'd0);
        tick;

`ifdef WB_ARB_STARVE_EN
        // Starvation: four denied cycles, then a forced LLU write with StallW
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h22;
        llu_valid = 1'b1; llu_rd = 5'd12; llu_data = 32'hC;
        expect_wr(5'd2, 32'h22, 1'b0);
        tick;
        llu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_wr(5'd2, 32'h22, 1'b0);
            tick;
        end
        expect_wr(5'd12, 32'hC, 1'b1);
        tick;
        expect_wr(5'd2, 32'h22, 1'b0);
        tick;
        RegWriteW = 1'b0;
        chk("starve_count", {30'd0, llu_count}, 32'd0);
        tick;
`endif

        // Reset with a full buffer: entries dropped, no stale write afterwards
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h33;
        llu_valid = 1'b1; llu_rd = 5'd13; llu_data = 32'hD;
        expect_wr(5'd3, 32'h33, 1'b0);
        tick;
        llu_rd = 5'd14; llu_data = 32'hE;
        expect_wr(5'd3, 32'h33, 1'b0);
        tick;
        llu_valid = 1'b0;
        chk("pre_reset_count", {30'd0, llu_count}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_count", {30'd0, llu_count}, 32'd0);
        chk("midrst_we3", {31'd0, WE3}, 32'd0);
        chk("midrst_ready", {31'd0, llu_ready}, 32'd0);
        tick;
        RegWriteW = 1'b0;
        rst_n = 1'b1;
        tick; tick; tick;
        chk("post_reset_count", {30'd0, llu_count}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register write-data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, long-latency-unit (LLU) result buffer entries, power of two, minimum 2.
REQ-004 SHALL have parameter MAX_WAIT, default 4, cycles a buffered LLU result may be denied before a forced grant.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port RegWriteW, input, 1, W-stage register write request.
REQ-008 SHALL have port RdW, input, ADDR_WIDTH, W-stage destination register.
REQ-009 SHALL have port ResultW, input, DATA_WIDTH, W-stage result from the writeback mux.
REQ-010 SHALL have port llu_valid, input, 1, LLU result offered.
REQ-011 SHALL have port llu_rd, input, ADDR_WIDTH, LLU destination register.
REQ-012 SHALL have port llu_data, input, DATA_WIDTH, LLU result.
REQ-013 SHALL have port llu_ready, output, 1, buffer can accept an LLU result this cycle.
REQ-014 SHALL have port WE3, output, 1, register-file write enable.
REQ-015 SHALL have port A3, output, ADDR_WIDTH, register-file write address.
REQ-016 SHALL have port WD3, output, DATA_WIDTH, register-file write data.
REQ-017 SHALL have port StallW, output, 1, W stage must hold its contents this cycle.
REQ-018 SHALL have port llu_count, output, $clog2(FIFO_DEPTH)+1, buffered LLU entries.

Function
REQ-019 SHALL accept an LLU result when llu_valid && llu_ready at a rising edge; llu_ready = (llu_count < FIFO_DEPTH); no same-cycle bypass when full.
REQ-020 SHALL discard accepted LLU results with llu_rd == 0 (handshake completes, no entry written).
REQ-021 SHALL route the pipeline combinationally (0-cycle latency): if RegWriteW && !force, then WE3=1, A3=RdW, WD3=ResultW.
REQ-022 SHALL otherwise, if llu_count > 0, drive WE3=1, A3/WD3 = FIFO head and pop the head at the next edge; else WE3=0, A3=0, WD3=0.
REQ-023 SHALL give an accepted LLU result a minimum enqueue-to-WE3 latency of 1 cycle.
REQ-024 SHALL support simultaneous push and pop in one cycle when not full; llu_count unchanged.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; write order equals acceptance order.
REQ-026 SHALL keep wait counter: increments each cycle the head is present and not granted, clears on pop or when empty, saturates at MAX_WAIT.
REQ-027 SHALL assert force when wait counter == MAX_WAIT and head present; force grants the head and asserts StallW=1 for that cycle.
REQ-028 SHALL drive StallW=0 whenever force is low; a stalled W-stage write is re-presented next cycle and never lost.

Reset
REQ-029 SHALL on rst_n low asynchronously empty the FIFO, clear pointers, wait counter, llu_count to 0.
REQ-030 SHALL hold WE3=0, StallW=0, llu_ready=0 while rst_n is low; llu_ready=1 from the first edge after release.
REQ-031 SHALL drop buffered LLU results when reset asserts mid-operation; no partial write issued.

Configuration
REQ-032 SHALL implement starvation forcing (REQ-026..027) only when WB_ARB_STARVE_EN is defined; otherwise no wait counter, StallW tied 0, LLU writes only in cycles with RegWriteW=0.

Verification
REQ-033 SHALL cover: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF, FIFO empty -> same-cycle WE3=1, A3=5, WD3=0xDEADBEEF, StallW=0.
REQ-034 SHALL cover: LLU push rd=7 data=0x11 with RegWriteW=0 -> next cycle WE3=1, A3=7, WD3=0x11, llu_count 1->0.
REQ-035 SHALL cover: two LLU pushes while RegWriteW held 1 -> llu_count=2, llu_ready=0, third llu_valid not accepted.
REQ-036 SHALL cover (WB_ARB_STARVE_EN): head pending, RegWriteW=1 continuous -> after 4 denied cycles StallW=1 one cycle with LLU write, then pipeline resumes.
REQ-037 SHALL cover: LLU push rd=0 -> handshake completes, llu_count stays 0, no WE3.
REQ-038 SHALL cover: rst_n low with llu_count=2 -> llu_count=0, WE3=0 immediately; no stale write after release.
